// File: rtl/deser_queue_p.sv
// deser_queue_p
//   Serial-to-parallel deserializer feeding a first-word-fall-through queue.
//   One bit from data_in is shifted in per write strobe. Each completed
//   DATA_WIDTH word is pushed into a DEPTH-entry queue. Words leave the
//   queue on dequeue strobes.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   data_in         serial bit, sampled on a write strobe
//   write_in        bit write request (edge or level, per EDGE_DETECT)
//   dequeue_in      pop request (edge or level, per EDGE_DETECT)
//   flush_in        synchronous clear of the queue and the partial word
//   queue_data_out  head word, or 0 when the queue is empty
//   queue_valid     queue non-empty
//   queue_full      occupancy == DEPTH
//   queue_count     occupancy
//   bit_count       bits held in the current partial word
//   overflow        sticky: a completed word was dropped (queue full)
//   underflow       sticky: pop strobe while empty
module deser_queue_p #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 8,
   parameter int MSB_FIRST   = 1,
   parameter int EDGE_DETECT = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            data_in,
   input  logic                            write_in,
   input  logic                            dequeue_in,
   input  logic                            flush_in,
   output logic [DATA_WIDTH-1:0]           queue_data_out,
   output logic                            queue_valid,
   output logic                            queue_full,
   output logic [$clog2(DEPTH+1)-1:0]      queue_count,
   output logic [$clog2(DATA_WIDTH+1)-1:0] bit_count,
   output logic                            overflow,
   output logic                            underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic                  wr_hist_q, wr_hist_d;
   logic                  deq_hist_q, deq_hist_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr_stb, deq_stb;
   logic [DATA_WIDTH-1:0] sr_shift;
   logic                  is_empty, is_full;
   logic                  word_done, do_push, do_pop, mem_we;

   always_comb begin
      wr_hist_d  = write_in;
      deq_hist_d = dequeue_in;
      wr_stb     = (EDGE_DETECT != 0) ? (write_in & ~wr_hist_q) : write_in;
      deq_stb    = (EDGE_DETECT != 0) ? (dequeue_in & ~deq_hist_q) : dequeue_in;

      if (MSB_FIRST != 0) begin
         sr_shift = {sr_q[DATA_WIDTH-2:0], data_in};
      end else begin
         sr_shift = {data_in, sr_q[DATA_WIDTH-1:1]};
      end

      is_empty  = (count_q == '0);
      is_full   = (count_q == FULL_CNT);
      word_done = wr_stb && (bit_cnt_q == LAST_BIT);
      do_pop    = deq_stb && !is_empty;
      // A same-cycle pop frees the slot a full queue needs for the push.
      do_push   = word_done && (!is_full || do_pop);

      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      mem_we      = 1'b0;

      if (flush_in) begin
         // Flush swallows any strobe this cycle; sticky flags survive.
         sr_d      = '0;
         bit_cnt_d = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
      end else begin
         if (wr_stb) begin
            sr_d      = sr_shift;
            bit_cnt_d = word_done ? '0 : bit_cnt_q + BW'(1);
         end
         if (do_push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
         if (word_done && !do_push) begin
            overflow_d = 1'b1;
         end
         if (deq_stb && is_empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // History regs start high so an input held across reset never strobes.
         wr_hist_q   <= 1'b1;
         deq_hist_q  <= 1'b1;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_hist_q   <= wr_hist_d;
         deq_hist_q  <= deq_hist_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; only the occupancy count qualifies its contents.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[wr_ptr_q] <= sr_shift;
      end
   end

   assign queue_data_out = is_empty ? '0 : mem_q[rd_ptr_q];
   assign queue_valid    = !is_empty;
   assign queue_full     = is_full;
   assign queue_count    = count_q;
   assign bit_count      = bit_cnt_q;
   assign overflow       = overflow_q;
   assign underflow      = underflow_q;

endmodule

// File: tb/tb_deser_queue_p.sv
// tb_deser_queue_p
//   Directed bench for deser_queue_p. The main instance runs with the default
//   configuration and is compared every cycle against a queue-level model.
//   Two extra instances cover LSB-first and level-strobe configurations.
module tb_deser_queue_p;

   localparam int W = 8;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic data_in = 1'b0, write_in = 1'b0, dequeue_in = 1'b0, flush_in = 1'b0;
   logic [7:0] qd;
   logic       qv, qf, ov, un;
   logic [3:0] qc, bc;

   logic data_b = 1'b0, write_b = 1'b0;
   logic [7:0] b_qd;
   logic       b_qv, b_qf, b_ov, b_un;
   logic [3:0] b_qc, b_bc;

   logic data_c = 1'b0, write_c = 1'b0;
   logic [7:0] c_qd;
   logic       c_qv, c_qf, c_ov, c_un;
   logic [3:0] c_qc, c_bc;

   int checks = 0;
   int failures = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   deser_queue_p #(.DATA_WIDTH(W), .DEPTH(D), .MSB_FIRST(1), .EDGE_DETECT(1)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
      .dequeue_in(dequeue_in), .flush_in(flush_in),
      .queue_data_out(qd), .queue_valid(qv), .queue_full(qf),
      .queue_count(qc), .bit_count(bc), .overflow(ov), .underflow(un)
   );

   deser_queue_p #(.DATA_WIDTH(W), .DEPTH(D), .MSB_FIRST(0), .EDGE_DETECT(1)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_b), .write_in(write_b),
      .dequeue_in(1'b0), .flush_in(1'b0),
      .queue_data_out(b_qd), .queue_valid(b_qv), .queue_full(b_qf),
      .queue_count(b_qc), .bit_count(b_bc), .overflow(b_ov), .underflow(b_un)
   );

   deser_queue_p #(.DATA_WIDTH(W), .DEPTH(D), .MSB_FIRST(1), .EDGE_DETECT(0)) dut_c (
      .clk(clk), .rst(rst), .data_in(data_c), .write_in(write_c),
      .dequeue_in(1'b0), .flush_in(1'b0),
      .queue_data_out(c_qd), .queue_valid(c_qv), .queue_full(c_qf),
      .queue_count(c_qc), .bit_count(c_bc), .overflow(c_ov), .underflow(c_un)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Queue-level model of the main instance.
   logic [7:0] mq[$];
   logic       mbits[W];
   int         nb = 0;
   logic       m_ovf = 1'b0, m_unf = 1'b0;
   logic       pw = 1'b1, pd = 1'b1;
   logic       ws, ds;
   logic [7:0] mword;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         nb = 0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
         pw = 1'b1;
         pd = 1'b1;
      end else begin
         ws = write_in && !pw;
         ds = dequeue_in && !pd;
         pw = write_in;
         pd = dequeue_in;
         if (flush_in) begin
            mq.delete();
            nb = 0;
         end else begin
            if (ds) begin
               if (mq.size() == 0) m_unf = 1'b1;
               else void'(mq.pop_front());
            end
            if (ws) begin
               mbits[nb] = data_in;
               nb++;
               if (nb == W) begin
                  mword = '0;
                  for (int i = 0; i < W; i++) mword[W-1-i] = mbits[i];
                  if (mq.size() < D) mq.push_back(mword);
                  else m_ovf = 1'b1;
                  nb = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_valid", int'(qv), int'(mq.size() != 0));
         chk("m_full", int'(qf), int'(mq.size() == D));
         chk("m_count", int'(qc), mq.size());
         chk("m_bitcount", int'(bc), nb);
         chk("m_overflow", int'(ov), int'(m_ovf));
         chk("m_underflow", int'(un), int'(m_unf));
         chk("m_head", int'(qd), (mq.size() != 0) ? int'(mq[0]) : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_bit(input logic b, input int hold);
      data_in = b;
      write_in = 1'b1;
      repeat (hold) tick();
      write_in = 1'b0;
      tick();
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = W - 1; i >= 0; i--) wr_bit(w[i], 1);
   endtask

   task automatic pop();
      dequeue_in = 1'b1;
      tick();
      dequeue_in = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   logic [7:0] pat;

   initial begin
      rst = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("rst_count", int'(qc), 0);
      chk("rst_bitcount", int'(bc), 0);
      chk("rst_valid", int'(qv), 0);

      // MSB-first word from long pulses
      pat = 8'b1011_0010;
      for (int i = W - 1; i >= 0; i--) wr_bit(pat[i], 10);
      chk("t1_word", int'(qd), 'hB2);
      chk("t1_count", int'(qc), 1);
      chk("t1_bitcount", int'(bc), 0);

      // LSB-first instance
      for (int i = W - 1; i >= 0; i--) begin
         data_b = pat[i];
         write_b = 1'b1;
         tick();
         write_b = 1'b0;
         tick();
      end
      chk("t2_lsb_word", int'(b_qd), 'h4D);
      chk("t2_lsb_count", int'(b_qc), 1);

      // Level-strobe instance: three cycles high gives three bits
      data_c = 1'b1;
      write_c = 1'b1;
      repeat (3) tick();
      write_c = 1'b0;
      chk("t2_level_bits", int'(c_bc), 3);
      write_c = 1'b1;
      repeat (5) tick();
      write_c = 1'b0;
      chk("t2_level_bits_wrap", int'(c_bc), 0);
      chk("t2_level_word", int'(c_qd), 'hFF);
      tick();

      // Fill, overflow, drain
      do_reset();
      for (int i = 1; i <= 8; i++) send_word(8'(i));
      chk("t3_full", int'(qf), 1);
      chk("t3_head", int'(qd), 'h01);
      send_word(8'h09);
      chk("t3_overflow", int'(ov), 1);
      chk("t3_count", int'(qc), 8);
      for (int i = 1; i <= 8; i++) begin
         chk("t3_drain", int'(qd), i);
         pop();
      end
      chk("t3_empty", int'(qv), 0);

      // Pop on empty
      pop();
      chk("t4_underflow", int'(un), 1);
      chk("t4_count", int'(qc), 0);

      // Full queue: final bit and pop on the same edge
      do_reset();
      for (int i = 0; i < 8; i++) send_word(8'(8'h10 + i));
      pat = 8'hAA;
      for (int i = W - 1; i >= 1; i--) wr_bit(pat[i], 1);
      data_in = pat[0];
      write_in = 1'b1;
      dequeue_in = 1'b1;
      tick();
      write_in = 1'b0;
      dequeue_in = 1'b0;
      tick();
      chk("t4_pp_count", int'(qc), 8);
      chk("t4_pp_overflow", int'(ov), 0);
      for (int i = 0; i < 7; i++) begin
         chk("t4_pp_drain", int'(qd), 'h11 + i);
         pop();
      end
      chk("t4_pp_tail", int'(qd), 'hAA);
      pop();

      // Partial word discarded by reset and by flush
      wr_bit(1'b1, 1); wr_bit(1'b0, 1); wr_bit(1'b1, 1);
      do_reset();
      chk("t5_rst_bits", int'(bc), 0);
      pop();
      wr_bit(1'b1, 1); wr_bit(1'b1, 1); wr_bit(1'b0, 1);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      tick();
      chk("t5_flush_bits", int'(bc), 0);
      chk("t5_flush_sticky", int'(un), 1);
      send_word(8'hF0);
      chk("t5_word", int'(qd), 'hF0);
      // Flush wins over a write strobe and empties the queue
      data_in = 1'b1;
      write_in = 1'b1;
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      write_in = 1'b0;
      tick();
      chk("t5_flush_wr_bits", int'(bc), 0);
      chk("t5_flush_count", int'(qc), 0);

      // write_in held high through reset release
      data_in = 1'b1;
      write_in = 1'b1;
      do_reset();
      repeat (3) tick();
      chk("t6_held_bits", int'(bc), 0);
      write_in = 1'b0;
      tick();
      write_in = 1'b1;
      tick();
      chk("t6_first_bit", int'(bc), 1);
      write_in = 1'b0;
      tick();
      pat = 8'hC3;
      for (int i = W - 2; i >= 0; i--) wr_bit(pat[i], 1);
      chk("t6_word", int'(qd), 'hC3);

      // Pointer wrap with words in flight
      do_reset();
      for (int i = 0; i < 3; i++) send_word(8'(8'h30 + i));
      for (int k = 0; k < 20; k++) begin
         send_word(8'(8'h33 + k));
         chk("t6_wrap_head", int'(qd), 'h30 + k);
         pop();
      end
      chk("t6_wrap_count", int'(qc), 3);
      chk("t6_wrap_last", int'(qd), 'h44);

      cmp_en = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
